// File: rtl/uart_regbank_v2.sv
// rtl/uart_regbank_v2.sv - APB-side UART register bank with RX FIFO, W1C status and interrupt
module uart_regbank_v2 #(
  parameter int ADDR_W    = 8,
  parameter int RX_DW     = 8,
  parameter int RXF_DEPTH = 8,
  parameter int LVL_W     = $clog2(RXF_DEPTH + 1)
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              regif_sel,
  input  logic              regif_enable,
  input  logic              regif_write,
  input  logic [ADDR_W-1:0] regif_addr,
  input  logic [31:0]       regif_wdata,
  input  logic [3:0]        regif_strb,
  output logic [31:0]       regif_rdata,
  output logic              regif_slverr,
  input  logic [RX_DW-1:0]  dout,
  input  logic              tx_done,
  input  logic              rx_done,
  input  logic              error,
  input  logic              BR_config_error,
  output logic [31:0]       baud_rate_tx,
  output logic [31:0]       baud_rate_rx,
  output logic [31:0]       frame_size,
  output logic [31:0]       parity_type,
  output logic [31:0]       clk_freq_reg,
  output logic [31:0]       transfer_data,
  output logic [31:0]       enable_reg,
  output logic              uart_enable,
  output logic              bclk_en,
  output logic              irq
);

  localparam int PTR_W = $clog2(RXF_DEPTH);

  localparam logic [ADDR_W-1:0] A_BAUD_TX   = ADDR_W'(8'h00);
  localparam logic [ADDR_W-1:0] A_FRAME     = ADDR_W'(8'h04);
  localparam logic [ADDR_W-1:0] A_PARITY    = ADDR_W'(8'h08);
  localparam logic [ADDR_W-1:0] A_CTRL      = ADDR_W'(8'h0C);
  localparam logic [ADDR_W-1:0] A_BAUD_RX   = ADDR_W'(8'h10);
  localparam logic [ADDR_W-1:0] A_INT_EN    = ADDR_W'(8'h14);
  localparam logic [ADDR_W-1:0] A_TX_DATA   = ADDR_W'(8'h18);
  localparam logic [ADDR_W-1:0] A_CLK_FREQ  = ADDR_W'(8'h1C);
  localparam logic [ADDR_W-1:0] A_STATUS    = ADDR_W'(8'h20);
  localparam logic [ADDR_W-1:0] A_RX_DATA   = ADDR_W'(8'h24);
  localparam logic [ADDR_W-1:0] A_FIFO_STAT = ADDR_W'(8'h28);

  logic [31:0]      baud_tx_q, frame_q, parity_q, ctrl_q;
  logic [31:0]      baud_rx_q, int_en_q, tx_data_q, clk_freq_q;
  logic [31:0]      ctrl_nxt;
  logic [4:0]       status_q, status_nxt;
  logic [RX_DW-1:0] fifo_mem [RXF_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level;

  logic        access, rd_acc, wr_acc, wr_commit;
  logic        mapped, is_ro, is_ctrl, is_status, is_rx_data;
  logic        fifo_empty, fifo_full, pop, push, overflow;
  logic [31:0] rd_mux, fifo_stat;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  assign access     = regif_sel & regif_enable;
  assign rd_acc     = access & ~regif_write;
  assign wr_acc     = access & regif_write;
  assign is_ctrl    = (regif_addr == A_CTRL);
  assign is_status  = (regif_addr == A_STATUS);
  assign is_rx_data = (regif_addr == A_RX_DATA);

  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == LVL_W'(RXF_DEPTH));
  assign fifo_stat  = {16'd0, 8'(level), 6'd0, fifo_full, fifo_empty};

  always_comb begin
    mapped = 1'b1;
    is_ro  = 1'b0;
    rd_mux = '0;
    case (regif_addr)
      A_BAUD_TX:   rd_mux = baud_tx_q;
      A_FRAME:     rd_mux = frame_q;
      A_PARITY:    rd_mux = parity_q;
      A_CTRL:      rd_mux = ctrl_q;
      A_BAUD_RX:   rd_mux = baud_rx_q;
      A_INT_EN:    rd_mux = int_en_q;
      A_TX_DATA:   rd_mux = tx_data_q;
      A_CLK_FREQ:  rd_mux = clk_freq_q;
      A_STATUS:    rd_mux = {27'd0, status_q};
      A_RX_DATA: begin
        is_ro  = 1'b1;
        rd_mux = fifo_empty ? 32'd0 : 32'(fifo_mem[rd_ptr]);
      end
      A_FIFO_STAT: begin
        is_ro  = 1'b1;
        rd_mux = fifo_stat;
      end
      default:     mapped = 1'b0;
    endcase
  end

  // A CTRL write while a baud configuration error is pending is refused.
  assign regif_slverr = access & (~mapped
                                  | (regif_write & is_ro)
                                  | (~regif_write & is_rx_data & fifo_empty)
                                  | (regif_write & is_ctrl & status_q[3]));

  assign regif_rdata = rd_acc ? rd_mux : 32'd0;
  assign wr_commit   = wr_acc & ~regif_slverr;

  assign pop      = rd_acc & is_rx_data & ~fifo_empty;
  assign overflow = rx_done & fifo_full & ~pop;
  assign push     = rx_done & ~overflow;

  always_comb begin
    ctrl_nxt = ctrl_q;
    if (wr_commit && is_ctrl) ctrl_nxt = merge(ctrl_q, regif_wdata, regif_strb);
    if (tx_done) ctrl_nxt[0] = 1'b0;
  end

  // Events are OR-ed in after the W1C clear so a coincident event survives.
  always_comb begin
    status_nxt = status_q;
    if (wr_commit && is_status && regif_strb[0]) status_nxt = status_q & ~regif_wdata[4:0];
    status_nxt = status_nxt | {overflow, BR_config_error, tx_done, rx_done, error};
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      baud_tx_q  <= '0;
      frame_q    <= '0;
      parity_q   <= '0;
      ctrl_q     <= '0;
      baud_rx_q  <= '0;
      int_en_q   <= '0;
      tx_data_q  <= '0;
      clk_freq_q <= '0;
      status_q   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      bclk_en    <= 1'b0;
      irq        <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_nxt;
      status_q <= status_nxt;
      irq      <= |(status_q & int_en_q[4:0]);
      bclk_en  <= wr_commit & ((regif_addr == A_BAUD_TX) | (regif_addr == A_BAUD_RX)
                               | (regif_addr == A_CLK_FREQ));
      if (wr_commit) begin
        case (regif_addr)
          A_BAUD_TX:  baud_tx_q  <= merge(baud_tx_q,  regif_wdata, regif_strb);
          A_FRAME:    frame_q    <= merge(frame_q,    regif_wdata, regif_strb);
          A_PARITY:   parity_q   <= merge(parity_q,   regif_wdata, regif_strb);
          A_BAUD_RX:  baud_rx_q  <= merge(baud_rx_q,  regif_wdata, regif_strb);
          A_INT_EN:   int_en_q   <= merge(int_en_q,   regif_wdata, regif_strb);
          A_TX_DATA:  tx_data_q  <= merge(tx_data_q,  regif_wdata, regif_strb);
          A_CLK_FREQ: clk_freq_q <= merge(clk_freq_q, regif_wdata, regif_strb);
          default:    ;
        endcase
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level + LVL_W'(push) - LVL_W'(pop);
    end
  end

  // Storage needs no reset: the head is masked whenever the level is zero.
  always_ff @(posedge PCLK) begin
    if (push) fifo_mem[wr_ptr] <= dout;
  end

  assign baud_rate_tx  = baud_tx_q;
  assign frame_size    = frame_q;
  assign parity_type   = parity_q;
  assign enable_reg    = ctrl_q;
  assign baud_rate_rx  = baud_rx_q;
  assign transfer_data = tx_data_q;
  assign clk_freq_reg  = clk_freq_q;
  assign uart_enable   = ctrl_q[0];

endmodule

// File: doc/uart_regbank_v2.md
Name: uart_regbank_v2

Overview:
- Second-generation APB-side register bank for the UART; sits between the APB interface (regif_* access signals) and the UART core.
- Adds byte-lane write strobes, error response, parametrised RX data FIFO, and sticky W1C status with overflow tracking.
- Adds a registered interrupt output and hardware self-clear of the TX enable bit.

Parameters:
- ADDR_W, 8, register address width (byte address).
- RX_DW, 8, received character width (5..9).
- RXF_DEPTH, 8, RX FIFO entries (power of two, >=2).
- LVL_W, $clog2(RXF_DEPTH+1), FIFO level width (derived).

Ports:
- PCLK  in  1  clock.
- PRESET  in  1  asynchronous reset, active-high.
- regif_sel  in  1  slave selected.
- regif_enable  in  1  access phase.
- regif_write  in  1  1 = write, 0 = read.
- regif_addr  in  ADDR_W  byte address.
- regif_wdata  in  32  write data.
- regif_strb  in  4  byte-lane write enables.
- regif_rdata  out  32  read data.
- regif_slverr  out  1  error response, valid in access phase.
- dout  in  RX_DW  received character.
- tx_done, rx_done, error, BR_config_error  in  1 each  single-cycle event pulses from the UART.
- baud_rate_tx, baud_rate_rx, frame_size, parity_type, clk_freq_reg, transfer_data, enable_reg  out  32 each  config registers.
- uart_enable  out  1  CTRL bit0.
- bclk_en  out  1  baud-generator reload pulse.
- irq  out  1  interrupt.

Behaviour:
- Access: an access is regif_sel & regif_enable; zero wait states. Writes commit on the access cycle. Only byte lanes with strb=1 update.
- Map:
  - 0x00 BAUD_TX, 0x04 FRAME, 0x08 PARITY, 0x0C CTRL, 0x10 BAUD_RX, 0x14 INT_EN, 0x18 TX_DATA, 0x1C CLK_FREQ: RW.
  - 0x20 STATUS: W1C.
  - 0x24 RX_DATA: RO, read pops the FIFO.
  - 0x28 FIFO_STAT: RO; {level[LVL_W-1:0] at [15:8], full [1], empty [0]}.
- Reset: all registers, FIFO pointers, status, bclk_en and irq are 0; regif_rdata is 0 while idle; FIFO_STAT reads empty=1.
- Read data: combinational mux on regif_addr. RX_DATA returns the zero-extended FIFO head. Unmapped addresses read 0.
- regif_slverr asserts on an access cycle for:
  - an unmapped address;
  - a write to a RO address;
  - a read of RX_DATA while empty (returns 0, no pop);
  - a write to CTRL while STATUS[3] is set (write discarded).
- CTRL bit0 (uart_enable) is a register. A tx_done pulse clears it the next edge; tx_done beats a simultaneous CTRL write.
- bclk_en: registered single-cycle pulse on the edge after any committed write to BAUD_TX, BAUD_RX or CLK_FREQ. Back-to-back writes give consecutive pulses.
- STATUS[4:0] = {rx_overflow, BR_config_error, tx_done, rx_done, error}.
  - Each bit sets on its event and holds.
  - Writing 1 to a bit clears it. The event wins when set and clear coincide.
  - Bits [31:5] read 0.
- irq <= |(STATUS[4:0] & INT_EN[4:0]), registered, so it follows a status change by one cycle. Clearing the status bit or its enable drops irq one cycle later.
- RX FIFO:
  - rx_done pushes dout.
  - Push while full and no same-cycle pop: data dropped, STATUS[4] set, contents unchanged.
  - Pop and push in the same cycle: legal at any level, including full (no overflow) and empty-with-push (no pop; slverr per rule above).
  - Pointers wrap modulo RXF_DEPTH; level is 0..RXF_DEPTH.
- PRESET asserted mid-transfer: immediate clear of all state. The access in flight is lost and no response is required.

Test Plan:
- Reset then read 0x00..0x28 -> all 0 except FIFO_STAT=0x0000_0001; irq=0; bclk_en=0.
- Write 0x00 data 0xAABBCCDD, strb=4'b0101; read 0x00 -> 0x00BB00DD; bclk_en high exactly one cycle after the write.
- Push 8 chars 0x11..0x18 via rx_done (RXF_DEPTH=8) -> FIFO_STAT=0x0000_0802. Ninth push 0x19 -> STATUS[4]=1. Eight RX_DATA reads -> 0x11..0x18 in order. Ninth read -> 0, slverr=1.
- INT_EN=0x04, CTRL=0x1, then pulse tx_done -> STATUS=0x04, uart_enable=0; irq rises one cycle after STATUS. Write STATUS 0x04 -> STATUS=0, irq falls one cycle later.
- Pulse BR_config_error, then write CTRL=0x1 -> slverr=1, uart_enable stays 0. Write STATUS 0x08, then CTRL=0x1 -> uart_enable=1.
- Simultaneous cases:
  - rx_done together with a W1C of STATUS bit1 -> bit1 stays 1.
  - FIFO full with a pop and push in the same cycle -> level stays 8, no overflow.
  - Unmapped address 0x30 -> slverr=1, rdata=0.
